clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//   Multi-channel programmable clock divider. Successor to the fixed /2,/4,/8 ripple divider.
//   Each channel owns a counter clocked by the single system clock, so there are no
//   derived-clock domains. Each channel produces a divided waveform and a one-cycle tick
//   (clock-enable) pulse on every rising edge of that waveform.
//   Divisors are runtime-programmable through a valid/ready config port.
//   Updates apply glitch-free at the channel's period boundary.
// PARAMETERS
//   NUM_CH   3  number of independent divider channels (1..4)
//   CNT_W    8  divisor/counter width; legal divisor 1..2^CNT_W-1
//   CH_W     2  width of cfg_ch; must satisfy 2^CH_W >= NUM_CH
//   DEF_DIV  2  divisor loaded into every channel on reset (1..2^CNT_W-1)
// PORTS
//   clk         in   1       system clock, all logic on posedge
//   reset       in   1       synchronous, active-high
//   en          in   NUM_CH  per-channel run enable
//   cfg_valid   in   1       config request valid
//   cfg_ready   out  1       config request can be accepted
//   cfg_ch      in   CH_W    target channel of config request
//   cfg_div     in   CNT_W   requested divisor N
//   div_clk_o   out  NUM_CH  divided waveform per channel (registered)
//   tick_o      out  NUM_CH  1-cycle pulse coincident with each div_clk_o rising edge
//   cfg_err_o   out  1       1-cycle pulse: accepted request was illegal and was dropped
// BEHAVIOUR
//   Reset (sync, active-high, dominates all inputs):
//   - cnt[i] <= DEF_DIV-1; active div[i] <= DEF_DIV; pend[i] <= 0
//   - div_clk_o, tick_o, cfg_err_o <= 0
//   Counting, channel i with en[i]=1 and active divisor N:
//   - Wrap: if cnt==N-1, then cnt<=0, div_clk_o<=1 and tick_o<=1. Otherwise cnt<=cnt+1 and tick_o<=0.
//   - Fall: if cnt+1 == N>>1 and there is no wrap, div_clk_o<=0.
//   - Result: high phase floor(N/2) cycles, low phase ceil(N/2) cycles. N=2 gives clk/2, 50% duty.
//   - N=1: div_clk_o held 1; tick_o=1 every enabled cycle.
//   - Because cnt resets to N-1, the first enabled cycle after reset wraps. tick_o and
//     div_clk_o go high 1 cycle after en rises.
//   Disable (en[i]=0):
//   - cnt <= div-1; div_clk_o <= 0; tick_o <= 0.
//   - Re-enable restarts phase with an immediate rising edge, as after reset.
//   Config handshake:
//   - cfg_ready = ~reset & ~pend[cfg_ch] when cfg_ch < NUM_CH; cfg_ready = ~reset otherwise.
//   - cfg_ready is combinational on cfg_ch.
//   - A transfer occurs when cfg_valid & cfg_ready. cfg_valid may stay high; a held request is
//     taken on the first ready cycle.
//   - Illegal request (cfg_div==0 or cfg_ch>=NUM_CH): accepted, dropped, cfg_err_o=1 the next
//     cycle. No channel state changes.
//   - Legal request: pend[ch]<=1, pdiv[ch]<=cfg_div.
//   Update application (glitch-free):
//   - Pending divisor is applied in the cycle the channel wraps: div<=pdiv, cnt<=0, pend<=0.
//     The new period starts with that rising edge.
//   - If the channel is disabled, the pending divisor is applied on the next clk (cnt<=pdiv-1).
//   - If the new divisor equals the old one, it is still applied at the wrap; the waveform is
//     unchanged.
//   - Accept and wrap in the same cycle: the request becomes pending and applies at the
//     following wrap, not the current one.
//   - No runt pulses: every high phase and low phase is a full phase of either the old or the
//     new divisor, never truncated.
//   Reset mid-operation: all pending requests are discarded; outputs return to reset values
//   on the next edge.
//   Arithmetic: counters are CNT_W bits unsigned; N>>1 is a floor shift. No overflow is
//   possible because cnt<=N-1.
// TESTING
//   1. Reset, en=3'b111 with DEF_DIV=2: tick_o all high 1 cycle later; div_clk_o toggles every
//      clk on all channels.
//   2. cfg ch0 div=5: after the next ch0 wrap, div_clk_o[0] is high 2 / low 3 cycles.
//      tick_o[0] is spaced exactly 5 cycles. ch1 and ch2 are unaffected.
//   3. Send ch1 div=8 then, while pending, ch1 div=3 held valid: cfg_ready is low until the
//      wrap applies 8. Then 3 is accepted. The waveform shows one or more full /8 periods,
//      then /3, with no runt.
//   4. cfg_div=0, and separately cfg_ch=3 with NUM_CH=3: cfg_err_o pulses once each;
//      divisors are unchanged.
//   5. div=1 on ch2: div_clk_o[2] is constant 1 and tick_o[2]=1 every cycle.
//      Drop en[2]: next cycle both outputs are 0.
//   6. Assert reset mid-period with ch0 pending: next cycle all outputs are 0 and pend is
//      cleared. After release, ch0 runs at DEF_DIV.

Source files
------------

// File: rtl/clk_div_prog.sv
// ----------------------------------------------------------------------------
// clk_div_prog
//   Multi-channel programmable clock divider. Every channel runs a counter on
//   the single system clock and produces a registered divided waveform plus a
//   one-cycle tick (clock-enable) on each rising edge of that waveform.
//   Divisors are reprogrammed through a valid/ready port; a new divisor is
//   held pending and only takes effect at the channel's period boundary, so
//   no high or low phase is ever truncated.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   reset      in   synchronous, active-high; dominates all inputs
//   en         in   [NUM_CH]  per-channel run enable
//   cfg_valid  in   config request valid
//   cfg_ready  out  config request can be accepted (combinational on cfg_ch)
//   cfg_ch     in   [CH_W]    target channel of the request
//   cfg_div    in   [CNT_W]   requested divisor (1..2^CNT_W-1)
//   div_clk_o  out  [NUM_CH]  divided waveform per channel
//   tick_o     out  [NUM_CH]  pulse coincident with each div_clk_o rising edge
//   cfg_err_o  out  pulse: an accepted request was illegal and was dropped
// ----------------------------------------------------------------------------
module clk_div_prog #(
    parameter int NUM_CH  = 3,
    parameter int CNT_W   = 8,
    parameter int CH_W    = 2,
    parameter int DEF_DIV = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] div_clk_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic              cfg_err_o
);

    logic [CNT_W-1:0]  cnt   [NUM_CH];
    logic [CNT_W-1:0]  div_q [NUM_CH];
    logic [CNT_W-1:0]  pdiv  [NUM_CH];
    logic [NUM_CH-1:0] pend;

    logic [NUM_CH-1:0] ch_hit;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] fall;
    logic              ready_raw;
    logic              xfer;
    logic              legal;

    // Request decode. A channel number outside 0..NUM_CH-1 matches nothing,
    // so it is always ready and always flagged illegal.
    always_comb begin
        ch_hit    = '0;
        ready_raw = 1'b1;
        wrap      = '0;
        fall      = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_hit[i] = (cfg_ch == CH_W'(i));
            if (ch_hit[i]) begin
                ready_raw = ~pend[i];
            end
            wrap[i] = (cnt[i] == div_q[i] - CNT_W'(1));
            // Falling edge lands after floor(N/2) high cycles.
            fall[i] = ((cnt[i] + CNT_W'(1)) == (div_q[i] >> 1));
        end
        cfg_ready = ~reset & ready_raw;
        xfer      = cfg_valid & cfg_ready;
        legal     = (|ch_hit) && (cfg_div != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_err_o <= 1'b0;
        end else begin
            cfg_err_o <= xfer & ~legal;
        end

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                cnt[i]       <= CNT_W'(DEF_DIV - 1);
                div_q[i]     <= CNT_W'(DEF_DIV);
                pdiv[i]      <= CNT_W'(DEF_DIV);
                pend[i]      <= 1'b0;
                div_clk_o[i] <= 1'b0;
                tick_o[i]    <= 1'b0;
            end else begin
                if (!en[i]) begin
                    // Parked at N-1 so the first enabled cycle wraps and
                    // produces an immediate rising edge.
                    div_clk_o[i] <= 1'b0;
                    tick_o[i]    <= 1'b0;
                    if (pend[i]) begin
                        div_q[i] <= pdiv[i];
                        cnt[i]   <= pdiv[i] - CNT_W'(1);
                        pend[i]  <= 1'b0;
                    end else begin
                        cnt[i] <= div_q[i] - CNT_W'(1);
                    end
                end else if (wrap[i]) begin
                    cnt[i]       <= '0;
                    div_clk_o[i] <= 1'b1;
                    tick_o[i]    <= 1'b1;
                    if (pend[i]) begin
                        div_q[i] <= pdiv[i];
                        pend[i]  <= 1'b0;
                    end
                end else begin
                    cnt[i]    <= cnt[i] + CNT_W'(1);
                    tick_o[i] <= 1'b0;
                    if (fall[i]) begin
                        div_clk_o[i] <= 1'b0;
                    end
                end

                // Acceptance requires pend==0, so this never collides with
                // the pend clear above; a request taken on a wrap cycle waits
                // for the following wrap.
                if (xfer && legal && ch_hit[i]) begin
                    pend[i] <= 1'b1;
                    pdiv[i] <= cfg_div;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// ----------------------------------------------------------------------------
// tb_clk_div_prog
//   Directed bench for clk_div_prog (NUM_CH=3, CNT_W=8, CH_W=2, DEF_DIV=2).
//   Inputs change 1 time unit after a rising edge; outputs are observed at the
//   same point, so each step shows the result of exactly one clock edge.
// ----------------------------------------------------------------------------
module tb_clk_div_prog;

    logic       clk;
    logic       reset;
    logic [2:0] en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [2:0] div_clk_o;
    logic [2:0] tick_o;
    logic       cfg_err_o;

    int n_assert = 0;
    int n_fail   = 0;

    clk_div_prog #(
        .NUM_CH (3),
        .CNT_W  (8),
        .CH_W   (2),
        .DEF_DIV(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .div_clk_o(div_clk_o),
        .tick_o   (tick_o),
        .cfg_err_o(cfg_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycles between two consecutive ticks of one channel; -1 on timeout.
    task automatic measure(input int ch, output int period);
        int p;
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            if (tick_o[ch]) seen = 1'b1;
        end
        p    = 0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            p++;
            if (tick_o[ch]) seen = 1'b1;
        end
        period = seen ? p : -1;
    endtask

    // ch1 after the div=8 request is accepted (m=1..16): one /8 period, then /3
    int exp_d1 [16] = '{0,1,1,1,1,0,0,0,0,1,0,0,1,0,0,1};
    int exp_t1 [16] = '{0,1,0,0,0,0,0,0,0,1,0,0,1,0,0,1};

    initial begin
        int per;
        int e0;
        int t0;
        int e12;

        reset     = 1'b1;
        en        = 3'b000;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_div   = 8'd0;

        // Reset state
        step();
        step();
        chk("rst_div_clk", int'(div_clk_o), 0);
        chk("rst_tick", int'(tick_o), 0);
        chk("rst_err", int'(cfg_err_o), 0);
        chk("rst_ready", int'(cfg_ready), 0);

        // 1. enable all at DEF_DIV=2: immediate edge, then toggle every clk
        reset = 1'b0;
        en    = 3'b111;
        step();
        chk("en_first_div", int'(div_clk_o), 7);
        chk("en_first_tick", int'(tick_o), 7);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("div2_clk", int'(div_clk_o), (k % 2 == 0) ? 7 : 0);
            chk("div2_tick", int'(tick_o), (k % 2 == 0) ? 7 : 0);
        end

        // 2. ch0 div=5, applied at ch0's next wrap
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = 8'd5;
        #1;
        chk("ch0_ready", int'(cfg_ready), 1);
        step();
        chk("ch0_acc_clk", int'(div_clk_o), 0);
        cfg_valid = 1'b0;
        #1;
        chk("ch0_pend_ready", int'(cfg_ready), 0);
        for (int k = 0; k <= 10; k++) begin
            step();
            e0  = ((k % 5) < 2) ? 1 : 0;
            t0  = ((k % 5) == 0) ? 1 : 0;
            e12 = (k % 2 == 0) ? 6 : 0;
            chk("div5_clk", int'(div_clk_o), e0 + e12);
            chk("div5_tick", int'(tick_o), t0 + e12);
        end

        // 3. ch1 div=8, then div=3 held while 8 is pending
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_div   = 8'd8;
        #1;
        chk("ch1_ready0", int'(cfg_ready), 1);
        for (int m = 1; m <= 16; m++) begin
            step();
            chk("ch1_clk", int'(div_clk_o[1]), exp_d1[m-1]);
            chk("ch1_tick", int'(tick_o[1]), exp_t1[m-1]);
            if (m == 1) begin
                cfg_div = 8'd3;
                #1;
                chk("ch1_held_ready", int'(cfg_ready), 0);
            end else if (m == 2) begin
                chk("ch1_ready_after_wrap", int'(cfg_ready), 1);
            end else if (m == 3) begin
                chk("ch1_pend3_ready", int'(cfg_ready), 0);
                cfg_valid = 1'b0;
            end
        end

        // 4. illegal requests: divisor 0, then channel 3
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = 8'd0;
        step();
        chk("err_div0", int'(cfg_err_o), 1);
        cfg_valid = 1'b0;
        step();
        chk("err_div0_clear", int'(cfg_err_o), 0);
        chk("err_div0_no_pend", int'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd3;
        cfg_div   = 8'd7;
        #1;
        chk("ch3_ready", int'(cfg_ready), 1);
        step();
        chk("err_ch3", int'(cfg_err_o), 1);
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        step();
        chk("err_ch3_clear", int'(cfg_err_o), 0);
        measure(0, per);
        chk("period_ch0", per, 5);
        measure(1, per);
        chk("period_ch1", per, 3);
        measure(2, per);
        chk("period_ch2", per, 2);

        // 5. ch2 div=1: constant high, tick every cycle; then disable
        cfg_valid = 1'b1;
        cfg_ch    = 2'd2;
        cfg_div   = 8'd1;
        step();
        cfg_valid = 1'b0;
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("div1_clk", int'(div_clk_o[2]), 1);
            chk("div1_tick", int'(tick_o[2]), 1);
        end
        en = 3'b011;
        step();
        chk("dis_clk", int'(div_clk_o[2]), 0);
        chk("dis_tick", int'(tick_o[2]), 0);

        // 6. reset with ch0 pending
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = 8'd9;
        step();
        cfg_valid = 1'b0;
        #1;
        chk("ch0_pend9", int'(cfg_ready), 0);
        reset = 1'b1;
        step();
        chk("mid_rst_clk", int'(div_clk_o), 0);
        chk("mid_rst_tick", int'(tick_o), 0);
        chk("mid_rst_ready", int'(cfg_ready), 0);
        reset = 1'b0;
        #1;
        chk("pend_cleared", int'(cfg_ready), 1);
        step();
        chk("post_rst_clk", int'(div_clk_o), 3);
        chk("post_rst_tick", int'(tick_o), 3);
        step();
        chk("post_rst_fall", int'(div_clk_o), 0);
        measure(0, per);
        chk("post_rst_period", per, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
